lms_adaptive_fir: RTL and testbench

Parametrised, sample-serial LMS adaptive FIR filter that combines filtering, error generation and coefficient adaptation in one clocked block. It computes `y = sum w[k]*x[n-k]` and `e = d - y`, then updates every coefficient with an LMS step using a single time-shared multiplier. It sits between the sample front end and downstream processing. Designed coefficients, such as Parks-McClellan output, are loaded through a write port before adaptation starts.

---
 rtl/lms_adaptive_fir.sv | 195 +++++++++++++++++++
 tb/tb_lms_adaptive_fir.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_adaptive_fir.sv
// Sample-serial LMS adaptive FIR: filter, error and coefficient update on one multiplier.
// Define LMS_SIGN_ERROR_EN for the sign-error update (UPDATE then needs no multiplier).
module lms_adaptive_fir #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 32,
    parameter int MU_SHIFT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic signed [DATA_W-1:0]  d_in,
    input  logic                      adapt_en,
    input  logic                      coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
    input  logic signed [COEF_W-1:0]  coef_wr_data,
    output logic signed [DATA_W-1:0]  y_out,
    output logic signed [DATA_W-1:0]  e_out,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int IW    = $clog2(TAPS);
    localparam int AW    = (DATA_W > COEF_W) ? DATA_W : COEF_W;
    localparam int PW    = AW + DATA_W;
    localparam int FW    = DATA_W + COEF_W;
    localparam int ACC_W = FW + IW;
    localparam int SUM_W = PW + 2;

    typedef enum logic [1:0] {
        IDLE,
        FILTER,
        ERROR,
        UPDATE
    } state_t;

    state_t                   r_state;
    logic [IW-1:0]            r_idx;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [COEF_W-1:0] r_w [TAPS];
    logic signed [DATA_W-1:0] r_d;
    logic                     r_adapt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_y;
    logic signed [DATA_W-1:0] r_e;
    logic                     r_ov;

    logic                     w_last;
    logic signed [AW-1:0]     w_mul_a;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_acc_sh;
    logic                     w_y_ovf;
    logic signed [DATA_W-1:0] w_y;
    logic signed [DATA_W:0]   w_diff;
    logic signed [DATA_W-1:0] w_e;
    logic signed [SUM_W-1:0]  w_term;
    logic signed [SUM_W-1:0]  w_sum;
    logic                     w_w_ovf;
    logic signed [COEF_W-1:0] w_wnew;

    assign in_ready  = (r_state == IDLE) && !coef_wr_en;
    assign busy      = (r_state != IDLE);
    assign y_out     = r_y;
    assign e_out     = r_e;
    assign out_valid = r_ov;
    assign w_last    = (r_idx == IW'(TAPS - 1));

    // The one multiplier: w*x while filtering, e*x while updating.
    always_comb begin
        w_mul_a = AW'(r_w[r_idx]);
`ifndef LMS_SIGN_ERROR_EN
        if (r_state == UPDATE) begin
            w_mul_a = AW'(r_e);
        end
`endif
        w_prod = PW'(w_mul_a) * PW'(r_x[r_idx]);
    end

    always_comb begin
        w_acc_sh = r_acc >>> (COEF_W - 1);
        w_y_ovf  = !((&w_acc_sh[ACC_W-1:DATA_W-1]) ||
                     !(|w_acc_sh[ACC_W-1:DATA_W-1]));
        if (w_y_ovf) begin
            w_y = {w_acc_sh[ACC_W-1], {(DATA_W-1){~w_acc_sh[ACC_W-1]}}};
        end else begin
            w_y = w_acc_sh[DATA_W-1:0];
        end
    end

    always_comb begin
        w_diff = (DATA_W+1)'(r_d) - (DATA_W+1)'(w_y);
        if (w_diff[DATA_W] != w_diff[DATA_W-1]) begin
            w_e = {w_diff[DATA_W], {(DATA_W-1){~w_diff[DATA_W]}}};
        end else begin
            w_e = w_diff[DATA_W-1:0];
        end
    end

`ifdef LMS_SIGN_ERROR_EN
    logic signed [DATA_W:0] w_xe;
    logic signed [DATA_W:0] w_xt;

    always_comb begin
        w_xe = (DATA_W+1)'(r_x[r_idx]);
        w_xt = '0;
        if (r_e[DATA_W-1]) begin
            w_xt = -w_xe;
        end else if (r_e != '0) begin
            w_xt = w_xe;
        end
        w_term = SUM_W'(w_xt >>> MU_SHIFT);
    end
`else
    always_comb begin
        w_term = SUM_W'(w_prod >>> (DATA_W - 1 + MU_SHIFT));
    end
`endif

    always_comb begin
        w_sum   = SUM_W'(r_w[r_idx]) + w_term;
        w_w_ovf = !((&w_sum[SUM_W-1:COEF_W-1]) ||
                    !(|w_sum[SUM_W-1:COEF_W-1]));
        if (w_w_ovf) begin
            w_wnew = {w_sum[SUM_W-1], {(COEF_W-1){~w_sum[SUM_W-1]}}};
        end else begin
            w_wnew = w_sum[COEF_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_d     <= '0;
            r_adapt <= 1'b0;
            r_acc   <= '0;
            r_y     <= '0;
            r_e     <= '0;
            r_ov    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            r_ov <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (coef_wr_en) begin
                        if (int'(coef_wr_addr) < TAPS) begin
                            r_w[coef_wr_addr] <= coef_wr_data;
                        end
                    end else if (in_valid) begin
                        r_x[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_d     <= d_in;
                        r_adapt <= adapt_en;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= FILTER;
                    end
                end
                FILTER: begin
                    r_acc <= r_acc + ACC_W'($signed(w_prod[FW-1:0]));
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= ERROR;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ERROR: begin
                    r_y     <= w_y;
                    r_e     <= w_e;
                    r_ov    <= 1'b1;
                    r_state <= r_adapt ? UPDATE : IDLE;
                end
                UPDATE: begin
                    r_w[r_idx] <= w_wnew;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_adaptive_fir.sv
// Randomised bench for lms_adaptive_fir against an arithmetic LMS model.
// Honours LMS_SIGN_ERROR_EN the same way the design does.
module tb_lms_adaptive_fir;

    localparam int TAPS = 4;
    localparam int MU   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic adapt_en = 1'b0;
    logic coef_wr_en = 1'b0;
    logic [1:0] coef_wr_addr = '0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] d_in = '0;
    logic signed [15:0] coef_wr_data = '0;
    logic in_ready;
    logic out_valid;
    logic busy;
    logic signed [15:0] y_out;
    logic signed [15:0] e_out;

    always #5 clk = ~clk;

    lms_adaptive_fir #(
        .DATA_W(16),
        .COEF_W(16),
        .TAPS(TAPS),
        .MU_SHIFT(MU)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x_in(x_in),
        .d_in(d_in),
        .adapt_en(adapt_en),
        .coef_wr_en(coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .y_out(y_out),
        .e_out(e_out),
        .out_valid(out_valid),
        .busy(busy)
    );

    typedef struct {
        int y;
        int e;
        bit a;
        int cyc;
    } exp_t;

    exp_t q[$];
    int got_y[$];
    int got_e[$];
    int m_w[TAPS];
    int m_x[TAPS];
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always @(posedge clk) cyc++;

    function automatic int s16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int gy(input int i);
        return (i < got_y.size()) ? got_y[i] : 32'h7fffffff;
    endfunction

    function automatic int ge(input int i);
        return (i < got_e.size()) ? got_e[i] : 32'h7fffffff;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
    endtask

    task automatic flush_model();
        q.delete();
        for (int k = 0; k < TAPS; k++) begin
            m_w[k] = 0;
            m_x[k] = 0;
        end
    endtask

    task automatic model_accept(input int x, input int d, input bit a, input int c);
        longint acc;
        longint t;
        int y;
        int e;
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = x;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(m_w[k]) * longint'(m_x[k]);
        y = sat16(acc >>> 15);
        e = sat16(longint'(d) - longint'(y));
        if (a) begin
            for (int k = 0; k < TAPS; k++) begin
`ifdef LMS_SIGN_ERROR_EN
                t = (e > 0) ? longint'(m_x[k]) : (e < 0) ? -longint'(m_x[k]) : 0;
                t = t >>> MU;
`else
                t = (longint'(e) * longint'(m_x[k])) >>> (15 + MU);
`endif
                m_w[k] = sat16(longint'(m_w[k]) + t);
            end
        end
        q.push_back('{y, e, a, c + TAPS + 1});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out_valid: got y=%0d e=%0d with nothing pending",
                         y_out, e_out);
            end else begin
                exp_t ex;
                ex = q.pop_front();
                chk("y_out", int'(y_out), ex.y);
                chk("e_out", int'(e_out), ex.e);
                chk("latency_cycle", cyc, ex.cyc);
                chk("busy_after_error", busy, ex.a);
                got_y.push_back(int'(y_out));
                got_e.push_back(int'(e_out));
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_total++;
            $display("FAIL idle_timeout: busy still 1 after 200 cycles");
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        wait_idle();
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'(addr);
        coef_wr_data = 16'(data);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        m_w[addr] = s16(data);
    endtask

    task automatic send(input int x, input int d, input bit a, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = 16'(x);
        d_in = 16'(d);
        adapt_en = a;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (ok) model_accept(s16(x), s16(d), a, acc_cyc);
        else begin
            n_total++;
            $display("FAIL accept_timeout: in_ready never rose for x=%0d", x);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL result_timeout: %0d results still pending", q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c1;
        int c2;
        int base;
        int ov_cnt;
        int exp_y2;
        int exp_e2;
        int exp_w0;

        reset_dut();
        #1;
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_e_out", int'(e_out), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        base = got_y.size();
        send(32'h7FFF, 0, 1'b0, c1);
        wait_done();
        chk("rst_sample_y", gy(base), 0);

        write_coef(0, 32'h4000);
        base = got_y.size();
        send(32'h2000, 0, 1'b0, c1);
        send(32'h2000, 0, 1'b0, c2);
        wait_done();
        chk("fixed_y", gy(base), 32'h1000);
        chk("fixed_e", ge(base), s16(32'hF000));
        chk("fixed_spacing", c2 - c1, TAPS + 2);

        write_coef(0, 32'h7FFF);
        base = got_y.size();
        send(32'h7FFF, 32'h8000, 1'b0, c1);
        wait_done();
        chk("sat_y", gy(base), 32'h7FFE);
        chk("sat_e", ge(base), s16(32'h8000));

`ifdef LMS_SIGN_ERROR_EN
        exp_w0 = 32'h1000;
        exp_y2 = 32'h0800;
        exp_e2 = 32'h3800;
`else
        exp_w0 = 32'h0800;
        exp_y2 = 32'h0400;
        exp_e2 = 32'h3C00;
`endif
        reset_dut();
        base = got_y.size();
        send(32'h4000, 32'h4000, 1'b1, c1);
        chk("model_w0", m_w[0], exp_w0);
        send(32'h4000, 32'h4000, 1'b1, c2);
        wait_done();
        chk("adapt_y1", gy(base), 0);
        chk("adapt_e1", ge(base), 32'h4000);
        chk("adapt_y2", gy(base + 1), exp_y2);
        chk("adapt_e2", ge(base + 1), exp_e2);
        chk("adapt_spacing", c2 - c1, 2 * TAPS + 2);

        write_coef(0, 32'h4000);
        send(32'h4000, 0, 1'b1, c1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_model();
        ov_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_out_valid", ov_cnt, 0);
        chk("abort_in_ready", in_ready, 1);
        base = got_y.size();
        send(32'h4000, 0, 1'b0, c1);
        wait_done();
        chk("abort_coef_cleared_y", gy(base), 0);

        @(negedge clk);
        coef_wr_en = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = 16'h2000;
        in_valid = 1'b1;
        x_in = 16'h4000;
        d_in = 16'h0000;
        adapt_en = 1'b0;
        #1;
        chk("wr_blocks_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        m_w[0] = 32'h2000;
        @(negedge clk);
        chk("ready_after_write", in_ready, 1);
        base = got_y.size();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(32'h4000, 0, 1'b0, cyc);
        wait_done();
        chk("wr_then_accept_y", gy(base), 32'h1000);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(s16(int'($urandom())), s16(int'($urandom())),
                 1'($urandom_range(0, 1)), c1);
        end
        wait_done();
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
